count_checker: RTL and testbench

//   Receive-side monitor for the free-running up-counter bus: samples count each enabled cycle,

---
 rtl/count_checker_pkg.sv | 12 +
 rtl/count_checker_sat_counter.sv | 27 ++
 rtl/count_checker.sv | 120 ++++++++++++
 tb/tb_count_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// rtl/count_checker_pkg.sv - shared state codes and defaults for the count checker
package count_checker_pkg;

   // FSM state codes, kept bit-compatible with the counter's own definitions
   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // Default width of the monitored count bus
   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/count_checker_sat_counter.sv
// rtl/count_checker_sat_counter.sv - saturating up-counter with synchronous clear
module count_checker_sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Count increments, holding at all-ones; clear overrides a same-cycle increment
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - receive-side monitor that locks onto and checks an up-counter bus
module count_checker
   import count_checker_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ERR_W    = 8,
   parameter int LOCK_CNT = 2,
   parameter int LOSS_CNT = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_sample_en,
   input  logic             i_clear,
   output logic             o_locked,
   output logic             o_err_pulse,
   output logic             o_err_flag,
   output logic [ERR_W-1:0] o_err_count,
   output logic [WIDTH-1:0] o_expected
);

   // Run counters only ever hold 0..N-1; reaching N is detected as "at N-1 and one more"
   localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam int MISS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

   logic [1:0]        r_state;
   logic [GOOD_W-1:0] r_good;
   logic [MISS_W-1:0] r_miss;
   logic [WIDTH-1:0]  r_expected;
   logic              r_err_pulse;
   logic              r_err_flag;

   logic              w_match;
   logic              w_err;
   logic              w_good_done;
   logic              w_miss_done;

   assign w_match     = (i_count == r_expected);
   assign w_err       = i_sample_en && (r_state == ST_LOCKED) && !w_match;
   assign w_good_done = (r_good == GOOD_W'(LOCK_CNT - 1));
   assign w_miss_done = (r_miss == MISS_W'(LOSS_CNT - 1));

   // Lock FSM, run counters and next-expected value; all frozen when no sample is offered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_HUNT;
         r_good     <= '0;
         r_miss     <= '0;
         r_expected <= '0;
      end else if (i_sample_en) begin
         // Every sample re-seeds the prediction, so one bad value costs one error, not a run
         r_expected <= i_count + 1'b1;
         case (r_state)
            ST_HUNT: begin
               r_state <= ST_SYNC;
               r_good  <= '0;
            end
            ST_SYNC: begin
               if (w_match) begin
                  if (w_good_done) begin
                     r_state <= ST_LOCKED;
                     r_good  <= '0;
                     r_miss  <= '0;
                  end else begin
                     r_good <= r_good + 1'b1;
                  end
               end else begin
                  r_good <= '0;
               end
            end
            ST_LOCKED: begin
               if (w_match) begin
                  r_miss <= '0;
               end else if (w_miss_done) begin
                  r_state <= ST_HUNT;
                  r_miss  <= '0;
               end else begin
                  r_miss <= r_miss + 1'b1;
               end
            end
            default: begin
               r_state <= ST_HUNT;
               r_good  <= '0;
               r_miss  <= '0;
            end
         endcase
      end
   end

   // Error pulse follows each locked mismatch; sticky flag yields to a same-cycle clear
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err_pulse <= 1'b0;
         r_err_flag  <= 1'b0;
      end else begin
         r_err_pulse <= w_err;
         if (i_clear) begin
            r_err_flag <= 1'b0;
         end else if (w_err) begin
            r_err_flag <= 1'b1;
         end
      end
   end

   count_checker_sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (w_err),
      .i_clr (i_clear),
      .o_q   (o_err_count)
   );

   assign o_locked    = (r_state == ST_LOCKED);
   assign o_err_pulse = r_err_pulse;
   assign o_err_flag  = r_err_flag;
   assign o_expected  = r_expected;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - randomized self-checking bench for count_checker
module tb_count_checker;

   localparam int LOCK_CNT = 2;
   localparam int LOSS_CNT = 3;

   logic       clk;
   logic       rst;
   logic [7:0] count;
   logic       en;
   logic       clr;

   logic       locked_a, pulse_a, flag_a;
   logic [7:0] errcnt_a, exp_a;
   logic       locked_b, pulse_b, flag_b;
   logic [1:0] errcnt_b;
   logic [7:0] exp_b;

   int n_checks;
   int n_fail;

   // reference model state
   bit seeded, m_locked, m_pulse, m_flag;
   int m_good, m_miss, m_exp, m_err8, m_err2;

   count_checker #(.WIDTH(8), .ERR_W(8), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
      .i_clk(clk), .i_rst(rst), .i_count(count), .i_sample_en(en), .i_clear(clr),
      .o_locked(locked_a), .o_err_pulse(pulse_a), .o_err_flag(flag_a),
      .o_err_count(errcnt_a), .o_expected(exp_a));

   count_checker #(.WIDTH(8), .ERR_W(2), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut_e2 (
      .i_clk(clk), .i_rst(rst), .i_count(count), .i_sample_en(en), .i_clear(clr),
      .o_locked(locked_b), .o_err_pulse(pulse_b), .o_err_flag(flag_b),
      .o_err_count(errcnt_b), .o_expected(exp_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      seeded = 0; m_locked = 0; m_pulse = 0; m_flag = 0;
      m_good = 0; m_miss = 0; m_exp = 0; m_err8 = 0; m_err2 = 0;
   endtask

   task automatic model_step(input int c, input bit e, input bit cl);
      m_pulse = 0;
      if (e) begin
         if (!seeded) begin
            seeded = 1;
            m_good = 0;
         end else if (!m_locked) begin
            if (c == m_exp) begin
               m_good++;
               if (m_good >= LOCK_CNT) begin
                  m_locked = 1;
                  m_miss = 0;
               end
            end else begin
               m_good = 0;
            end
         end else if (c == m_exp) begin
            m_miss = 0;
         end else begin
            m_pulse = 1;
            m_flag = 1;
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
            m_miss++;
            if (m_miss >= LOSS_CNT) begin
               m_locked = 0;
               seeded = 0;
               m_miss = 0;
            end
         end
         m_exp = (c + 1) % 256;
      end
      if (cl) begin
         m_flag = 0;
         m_err8 = 0;
         m_err2 = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".locked"},  locked_a, m_locked);
      chk({tag, ".pulse"},   pulse_a,  m_pulse);
      chk({tag, ".flag"},    flag_a,   m_flag);
      chk({tag, ".errcnt"},  errcnt_a, m_err8);
      chk({tag, ".expect"},  exp_a,    m_exp);
      chk({tag, ".locked2"}, locked_b, m_locked);
      chk({tag, ".pulse2"},  pulse_b,  m_pulse);
      chk({tag, ".flag2"},   flag_b,   m_flag);
      chk({tag, ".errcnt2"}, errcnt_b, m_err2);
   endtask

   task automatic step(input string tag, input int c, input bit e, input bit cl);
      count = c[7:0];
      en    = e;
      clr   = cl;
      @(posedge clk);
      model_step(c, e, cl);
      #1;
      check_all(tag);
   endtask

   initial begin
      int cur;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0; count = '0; en = 1'b0; clr = 1'b0;
      model_reset();
      #5 rst = 1'b1;
      #4 rst = 1'b0;
      #1 check_all("reset");

      // 1: continuous count through the 255->0 wrap
      for (int i = 0; i < 260; i++) begin
         step("t1", i % 256, 1, 0);
         if (i == 1) chk("t1.not_yet_locked", locked_a, 0);
         if (i == 2) chk("t1.locked_after_s2", locked_a, 1);
      end
      chk("t1.no_err_wrap", errcnt_a, 0);

      // 2: single bad sample while locked
      for (int v = 4; v <= 'h36; v++) step("t2run", v, 1, 0);
      step("t2bad", 'h40, 1, 0);
      chk("t2.pulse", pulse_a, 1);
      chk("t2.errcnt", errcnt_a, 1);
      chk("t2.flag", flag_a, 1);
      chk("t2.still_locked", locked_a, 1);
      step("t2good", 'h41, 1, 0);
      chk("t2.pulse_off", pulse_a, 0);
      chk("t2.exp_after", exp_a, 'h42);

      // 3: three consecutive bad samples drop lock, clean run relocks
      step("t3bad", 'h90, 1, 0);
      step("t3bad", 'h10, 1, 0);
      chk("t3.locked_before_third", locked_a, 1);
      step("t3bad", 'hA0, 1, 0);
      chk("t3.unlocked", locked_a, 0);
      chk("t3.errcnt", errcnt_a, 4);
      for (int k = 1; k <= 1 + LOCK_CNT; k++) begin
         step("t3relock", 'hA0 + k, 1, 0);
         if (k == LOCK_CNT) chk("t3.not_relocked_yet", locked_a, 0);
      end
      chk("t3.relocked", locked_a, 1);

      // 4: sample_en toggling, count held while disabled
      cur = 'hA4;
      for (int k = 0; k < 12; k++) begin
         step("t4on", cur, 1, 0);
         step("t4off", (k == 5) ? 'h5A : cur, 0, 0);
         chk("t4.frozen", exp_a, (cur + 1) % 256);
         cur = (cur + 1) % 256;
      end

      // 5: isolated errors saturate the 2-bit counter; clear wins over an error
      step("t5clr", cur, 1, 1);
      cur = (cur + 1) % 256;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 2; j++) begin
            step("t5run", cur, 1, 0);
            cur = (cur + 1) % 256;
         end
         cur = (cur + 'h20) % 256;
         step("t5err", cur, 1, 0);
         cur = (cur + 1) % 256;
      end
      chk("t5.sat2", errcnt_b, 3);
      chk("t5.cnt8", errcnt_a, 5);
      chk("t5.pulse_at_sat", pulse_b, 1);
      chk("t5.locked", locked_a, 1);
      cur = (cur + 'h11) % 256;
      step("t5clrerr", cur, 1, 1);
      chk("t5.clr_cnt", errcnt_b, 0);
      chk("t5.clr_flag", flag_a, 0);
      chk("t5.clr_pulse", pulse_a, 1);
      cur = (cur + 1) % 256;

      // randomized run: mostly sequential, occasional jumps, gaps and clears
      for (int k = 0; k < 400; k++) begin
         int r;
         int c;
         bit e;
         r = $urandom_range(0, 99);
         e = (r < 85);
         c = (r < 8 || !e) ? $urandom_range(0, 255) : cur;
         if (r == 2) c = 0;
         step("rand", c, e, ($urandom_range(0, 39) == 0));
         if (e) cur = (c + 1) % 256;
      end

      // 6: asynchronous reset between edges while locked with an error pending
      for (int k = 0; k < 6; k++) begin
         step("t6run", cur, 1, 0);
         cur = (cur + 1) % 256;
      end
      step("t6err", (cur + 9) % 256, 1, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("t6.locked", locked_a, 0);
      chk("t6.pulse", pulse_a, 0);
      chk("t6.flag", flag_a, 0);
      chk("t6.errcnt", errcnt_a, 0);
      chk("t6.expect", exp_a, 0);
      chk("t6.errcnt2", errcnt_b, 0);
      #2 rst = 1'b0;
      step("t6seed", 'h77, 1, 0);
      chk("t6.hunt_no_lock", locked_a, 0);
      step("t6run2", 'h78, 1, 0);
      step("t6run3", 'h79, 1, 0);
      chk("t6.relock", locked_a, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
